// File: rtl/nuc_vga_pkg.sv
// Shared defaults, frame-geometry helpers and colour type for the nuclear VGA display path.
package nuc_vga_pkg;

    localparam int DEF_CLK_DIV    = 4;
    localparam int DEF_H_ACTIVE   = 640;
    localparam int DEF_H_FP       = 16;
    localparam int DEF_H_SYNC     = 96;
    localparam int DEF_H_BP       = 48;
    localparam int DEF_V_ACTIVE   = 480;
    localparam int DEF_V_FP       = 10;
    localparam int DEF_V_SYNC     = 2;
    localparam int DEF_V_BP       = 33;
    localparam int DEF_COLOR_BITS = 4;
    localparam int DEF_BOX_W      = 128;
    localparam int DEF_BOX_H      = 96;

    typedef struct packed {
        logic [DEF_COLOR_BITS-1:0] r;
        logic [DEF_COLOR_BITS-1:0] g;
        logic [DEF_COLOR_BITS-1:0] b;
    } rgb_t;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/nuc_vga_timing.sv
// Pixel-tick divider, h/v raster counters and stage-1 registered decodes
// (position, active area, sync windows, start-of-frame marker).
module nuc_vga_timing
    import nuc_vga_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    localparam int HW = $clog2(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
    localparam int VW = $clog2(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          tick,
    output logic          vblank_pos,
    output logic [HW-1:0] x,
    output logic [VW-1:0] y,
    output logic          active,
    output logic          hs,
    output logic          vs,
    output logic          sof
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DW-1:0] div;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;

    assign tick       = (div == DIV_LAST);
    assign vblank_pos = (h_cnt == '0) && (v_cnt == V_ACT);

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div   <= '0;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            div <= tick ? '0 : div + 1'b1;
            if (tick) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

    // div == 0 marks the first clock a new position is held, so sof is one clock wide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x      <= '0;
            y      <= '0;
            active <= 1'b0;
            hs     <= 1'b0;
            vs     <= 1'b0;
            sof    <= 1'b0;
        end else begin
            x      <= h_cnt;
            y      <= v_cnt;
            active <= (h_cnt < H_ACT) && (v_cnt < V_ACT);
            hs     <= (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
            vs     <= (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
            sof    <= (h_cnt == '0) && (v_cnt == '0) && (div == '0);
        end
    end

endmodule

// File: rtl/nuclear_vga_core.sv
// Parametrised VGA core: frame-latched switch background with centred inverse box.
// Optional NUC_BOX_BLINK_EN blinks the box with a 64-frame period.
module nuclear_vga_core
    import nuc_vga_pkg::*;
#(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit SYNC_POL   = 1'b0,
    parameter int COLOR_BITS = DEF_COLOR_BITS,
    parameter int BOX_W      = DEF_BOX_W,
    parameter int BOX_H      = DEF_BOX_H
) (
    input  logic                    clk_100MHz,
    input  logic                    reset,
    input  logic [3*COLOR_BITS-1:0] sw,
    output logic                    hsync,
    output logic                    vsync,
    output logic [3*COLOR_BITS-1:0] rgb,
    output logic                    video_on,
    output logic                    frame_start
);

    localparam int CW = 3 * COLOR_BITS;
    localparam int HW = $clog2(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
    localparam int VW = $clog2(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP));

    localparam logic [HW-1:0] BOX_X0 = HW'((H_ACTIVE - BOX_W) / 2);
    localparam logic [HW-1:0] BOX_X1 = HW'((H_ACTIVE - BOX_W) / 2 + BOX_W - 1);
    localparam logic [VW-1:0] BOX_Y0 = VW'((V_ACTIVE - BOX_H) / 2);
    localparam logic [VW-1:0] BOX_Y1 = VW'((V_ACTIVE - BOX_H) / 2 + BOX_H - 1);
    localparam logic          SYNC_ON  = SYNC_POL;
    localparam logic          SYNC_OFF = ~SYNC_POL;

    typedef struct packed {
        logic [COLOR_BITS-1:0] r;
        logic [COLOR_BITS-1:0] g;
        logic [COLOR_BITS-1:0] b;
    } color_t;

    logic [1:0]    rst_pipe;
    logic          rst_n;
    logic          tick, vblank_pos, active, hs, vs, sof;
    logic [HW-1:0] x;
    logic [VW-1:0] y;
    color_t        sw_meta, sw_sync, frame_color;
    logic [CW-1:0] bg;
    logic          in_box, box_on;

    // Reset asserts immediately but releases two clocks later, synchronous to clk.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) rst_pipe <= 2'b00;
        else        rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n = rst_pipe[1];

    nuc_vga_timing #(
        .CLK_DIV  (CLK_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk        (clk_100MHz),
        .rst_n      (rst_n),
        .tick       (tick),
        .vblank_pos (vblank_pos),
        .x          (x),
        .y          (y),
        .active     (active),
        .hs         (hs),
        .vs         (vs),
        .sof        (sof)
    );

    // Colour is only sampled at the start of vertical blanking, never mid-frame.
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta     <= '0;
            sw_sync     <= '0;
            frame_color <= '0;
        end else begin
            sw_meta <= color_t'(sw);
            sw_sync <= sw_meta;
            if (tick && vblank_pos) frame_color <= sw_sync;
        end
    end

    assign bg     = frame_color;
    assign in_box = (x >= BOX_X0) && (x <= BOX_X1) && (y >= BOX_Y0) && (y <= BOX_Y1);

`ifdef NUC_BOX_BLINK_EN
    logic [5:0] blink_cnt;

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n)           blink_cnt <= '0;
        else if (frame_start) blink_cnt <= blink_cnt + 1'b1;
    end
    assign box_on = in_box && !blink_cnt[5];
`else
    assign box_on = in_box;
`endif

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= SYNC_OFF;
            vsync       <= SYNC_OFF;
            rgb         <= '0;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= hs ? SYNC_ON : SYNC_OFF;
            vsync       <= vs ? SYNC_ON : SYNC_OFF;
            rgb         <= active ? (box_on ? ~bg : bg) : '0;
            video_on    <= active;
            frame_start <= sof;
        end
    end

endmodule

// File: doc/nuclear_vga_core.md
Name: nuclear_vga_core

Overview:
Parametrised successor to the fixed 640x480 nuclear display path. Generates VGA timing from the 100 MHz system clock through a configurable pixel-tick divider, with programmable porch/sync widths, sync polarity and colour depth. Draws a switch-selected background with a centred inverse-colour "core" box. Switch input is synchronised and frame-latched so colours never change mid-frame. Sits directly under nuclear_top, replacing the simple display instance.

Parameters:
CLK_DIV, 4, system clocks per pixel tick (>=1)
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
COLOR_BITS, 4, bits per colour channel
BOX_W, 128, core box width (pixels)
BOX_H, 96, core box height (lines)

Ports:
clk_100MHz  in  1  system clock
reset  in  1  asynchronous, active-low reset
sw  in  3*COLOR_BITS  background colour {R,G,B}, asynchronous to clk
hsync  out  1  horizontal sync, polarity per SYNC_POL
vsync  out  1  vertical sync, polarity per SYNC_POL
rgb  out  3*COLOR_BITS  pixel colour {R,G,B}
video_on  out  1  high while the pixel on rgb is in the active area
frame_start  out  1  one-clock pulse aligned with the first active pixel of each frame

Behaviour:
- Reset (reset=0, async assert, sync deassert through a 2-flop release): div, h_cnt, v_cnt = 0; hsync = vsync = ~SYNC_POL; rgb = 0; video_on = 0; frame_start = 0; latched colour = 0. Reset mid-frame restarts at pixel (0,0) after release.
- Divider: counts 0..CLK_DIV-1; tick = (div == CLK_DIV-1). CLK_DIV = 1 gives tick every cycle.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. On tick: h_cnt wraps at H_TOTAL-1 -> 0 and increments v_cnt; v_cnt wraps at V_TOTAL-1 -> 0.
- Sync active when h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (same rule for v).
- Switch path: 2-flop synchroniser on sw; synchronised value loaded into the frame colour register on the tick where h_cnt = 0 and v_cnt = V_ACTIVE (start of vertical blanking). Switch changes during the active area take effect on the next frame only.
- Pixel: inside the box when x in [(H_ACTIVE-BOX_W)/2, +BOX_W-1] and y in [(V_ACTIVE-BOX_H)/2, +BOX_H-1]; box colour = bitwise inverse of the frame colour, otherwise the frame colour; outside the active area rgb = 0.
- Pipeline: stage 1 registers counters and decodes; stage 2 registers rgb, hsync, vsync, video_on and frame_start. All outputs share a 2-clock latency from the counter update, so sync and colour stay aligned. Outputs hold between ticks.
- frame_start: high for exactly one clk_100MHz cycle, in the first cycle in which stage 2 presents (0,0).

Optional Feature:
NUC_BOX_BLINK_EN: when defined, a 6-bit frame counter increments at each frame_start, and the box is drawn in the background colour (invisible) while counter bit 5 = 1, i.e. it blinks with a 64-frame period. When undefined, there is no counter and the box is always drawn.

Decomposition:
- Package nuc_vga_pkg: default 640x480 timing constants, H_TOTAL/V_TOTAL helper functions, and the colour-struct typedef.
- Sub-module nuc_vga_timing: divider, h/v counters, sync decode and stage-1 registers, exposing x, y, active, hs, vs and tick.

Test Plan:
- Reset held low for 10 cycles, then released -> hsync = vsync = 1, rgb = 0 throughout reset; first tick 4 clocks after release.
- Defaults, one full frame -> hsync low for 96*4 = 384 clocks per line, line period 3200 clocks, vsync low for 2*3200 = 6400 clocks, frame period 1,680,000 clocks.
- sw = 12'hF00 before the frame -> background rgb = 12'hF00; pixel (320,240) = 12'h0FF; blanking pixels = 0.
- sw changed to 12'h0F0 at line 100 -> remainder of the frame stays 12'hF00; next frame is 12'h0F0.
- Parameters CLK_DIV = 1, H_ACTIVE = 8, V_ACTIVE = 4, small porches -> counters wrap correctly and frame_start pulses once per frame for exactly one cycle.
- reset asserted mid-line 200 -> outputs go to reset values immediately; after release, frame_start occurs at the first (0,0).
